poly_drawer: RTL and testbench

Draws one closed polygon entity (ship, asteroid or shot outline) as a chain of Bresenham line segments onto the VGA adapter's pixel-write port. It sits directly downstream of the entity draw controller. The controller supplies a shape base address, vertex count, screen origin and colour, pulses `start`, and waits for `draw_done`. Vertices are read from an external synchronous shape ROM; every pixel is emitted one per cycle as x/y/colour with a `plot` strobe.

---
 rtl/poly_drawer.sv | 223 ++++++++++++++++++++++
 tb/tb_poly_drawer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_drawer.sv
// poly_drawer: draws one closed polygon as a chain of Bresenham edges onto a pixel-write port.
// Latency: ROM address of vertex 0 one cycle after start, first pixel six cycles after start, then one pixel per cycle.
// Backpressure: none; the pixel port is always ready and start is ignored while a draw is in progress.
// Ports: start/shape_base/num_vertices/origin_x/origin_y/colour request a draw; vertex_addr/vertex_data
//        read the synchronous shape ROM; x/y/colour_out/plot write pixels; busy and draw_done report progress.
module poly_drawer #(
  parameter int ADDR_W   = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] shape_base,
  input  logic [4:0]        num_vertices,
  input  logic [7:0]        origin_x,
  input  logic [6:0]        origin_y,
  input  logic [2:0]        colour,
  output logic [ADDR_W-1:0] vertex_addr,
  input  logic [15:0]       vertex_data,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour_out,
  output logic              plot,
  output logic              busy,
  output logic              draw_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_A, S_LOAD_A, S_FETCH_B, S_LOAD_B,
    S_LINE_INIT, S_LINE_STEP, S_NEXT_EDGE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_r, base_nxt;
  logic [4:0]          num_r, num_nxt, idx, idx_nxt;
  logic [7:0]          ox_r, ox_nxt;
  logic [6:0]          oy_r, oy_nxt;
  logic [2:0]          col_r, col_nxt;
  logic                closing, closing_nxt;
  logic signed [9:0]   cx, cy, x1, y1, v0x, v0y;
  logic signed [9:0]   cx_nxt, cy_nxt, x1_nxt, y1_nxt, v0x_nxt, v0y_nxt;
  logic signed [10:0]  ddx, ddy, err, ddx_nxt, ddy_nxt, err_nxt;
  logic                sx_neg, sy_neg, sx_neg_nxt, sy_neg_nxt;
  logic                plot_r, plot_nxt;

  // Screen position of the vertex arriving from ROM: zero-extended origin plus sign-extended offset.
  logic signed [9:0] vx, vy;
  assign vx = $signed({2'b00, ox_r}) + $signed({{2{vertex_data[15]}}, vertex_data[15:8]});
  assign vy = $signed({3'b000, oy_r}) + $signed({{2{vertex_data[7]}}, vertex_data[7:0]});

  logic signed [10:0] dx_raw, dy_raw;
  assign dx_raw = {x1[9], x1} - {cx[9], cx};
  assign dy_raw = {y1[9], y1} - {cy[9], cy};

  logic signed [11:0] e2, ddx_w, ddy_w;
  logic               step_x, step_y;
  assign e2     = {err, 1'b0};
  assign ddx_w  = {ddx[10], ddx};
  assign ddy_w  = {ddy[10], ddy};
  assign step_x = (e2 >= ddy_w);
  assign step_y = (e2 <= ddx_w);

  logic [5:0] idx_inc;
  assign idx_inc = {1'b0, idx} + 6'd1;

  always_comb begin
    vertex_addr = '0;
    if (state == S_FETCH_A)      vertex_addr = base_r;
    else if (state == S_FETCH_B) vertex_addr = base_r + ADDR_W'(idx);
  end

  always_comb begin
    state_nxt   = state;
    base_nxt    = base_r;
    num_nxt     = num_r;
    ox_nxt      = ox_r;
    oy_nxt      = oy_r;
    col_nxt     = col_r;
    idx_nxt     = idx;
    closing_nxt = closing;
    cx_nxt      = cx;
    cy_nxt      = cy;
    x1_nxt      = x1;
    y1_nxt      = y1;
    v0x_nxt     = v0x;
    v0y_nxt     = v0y;
    ddx_nxt     = ddx;
    ddy_nxt     = ddy;
    err_nxt     = err;
    sx_neg_nxt  = sx_neg;
    sy_neg_nxt  = sy_neg;
    case (state)
      S_IDLE: begin
        if (start) begin
          base_nxt    = shape_base;
          num_nxt     = num_vertices;
          ox_nxt      = origin_x;
          oy_nxt      = origin_y;
          col_nxt     = colour;
          idx_nxt     = 5'd1;
          closing_nxt = 1'b0;
          state_nxt   = (num_vertices == 5'd0) ? S_DONE : S_FETCH_A;
        end
      end
      S_FETCH_A: state_nxt = S_LOAD_A;
      S_LOAD_A: begin
        cx_nxt    = vx;
        cy_nxt    = vy;
        v0x_nxt   = vx;
        v0y_nxt   = vy;
        state_nxt = S_FETCH_B;
      end
      S_FETCH_B: state_nxt = S_LOAD_B;
      S_LOAD_B: begin
        // A single-vertex shape has only the closing edge v0->v0; the fetched word is discarded.
        if (num_r == 5'd1) begin
          x1_nxt      = v0x;
          y1_nxt      = v0y;
          closing_nxt = 1'b1;
        end else begin
          x1_nxt = vx;
          y1_nxt = vy;
        end
        state_nxt = S_LINE_INIT;
      end
      S_LINE_INIT: begin
        ddx_nxt    = dx_raw[10] ? -dx_raw : dx_raw;
        ddy_nxt    = dy_raw[10] ? dy_raw : -dy_raw;
        err_nxt    = ddx_nxt + ddy_nxt;
        sx_neg_nxt = dx_raw[10];
        sy_neg_nxt = dy_raw[10];
        state_nxt  = S_LINE_STEP;
      end
      S_LINE_STEP: begin
        if (cx == x1 && cy == y1) begin
          state_nxt = S_NEXT_EDGE;
        end else begin
          // Both axis tests use the pre-update e2, so a diagonal move is a single step.
          err_nxt = err + (step_x ? ddy : 11'sd0) + (step_y ? ddx : 11'sd0);
          if (step_x) cx_nxt = cx + (sx_neg ? -10'sd1 : 10'sd1);
          if (step_y) cy_nxt = cy + (sy_neg ? -10'sd1 : 10'sd1);
        end
      end
      S_NEXT_EDGE: begin
        cx_nxt  = x1;
        cy_nxt  = y1;
        idx_nxt = idx_inc[4:0];
        if (closing) begin
          state_nxt = S_DONE;
        end else if (idx_inc < {1'b0, num_r}) begin
          state_nxt = S_FETCH_B;
        end else begin
          x1_nxt      = v0x;
          y1_nxt      = v0y;
          closing_nxt = 1'b1;
          state_nxt   = S_LINE_INIT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // plot is registered from the next-cycle position so it lines up with the cx/cy registers.
    plot_nxt = (state_nxt == S_LINE_STEP) &&
               !cx_nxt[9] && (int'(cx_nxt) < SCREEN_W) &&
               !cy_nxt[9] && (int'(cy_nxt) < SCREEN_H);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      base_r  <= '0;
      num_r   <= '0;
      ox_r    <= '0;
      oy_r    <= '0;
      col_r   <= '0;
      idx     <= '0;
      closing <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      x1      <= '0;
      y1      <= '0;
      v0x     <= '0;
      v0y     <= '0;
      ddx     <= '0;
      ddy     <= '0;
      err     <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      plot_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      base_r  <= base_nxt;
      num_r   <= num_nxt;
      ox_r    <= ox_nxt;
      oy_r    <= oy_nxt;
      col_r   <= col_nxt;
      idx     <= idx_nxt;
      closing <= closing_nxt;
      cx      <= cx_nxt;
      cy      <= cy_nxt;
      x1      <= x1_nxt;
      y1      <= y1_nxt;
      v0x     <= v0x_nxt;
      v0y     <= v0y_nxt;
      ddx     <= ddx_nxt;
      ddy     <= ddy_nxt;
      err     <= err_nxt;
      sx_neg  <= sx_neg_nxt;
      sy_neg  <= sy_neg_nxt;
      plot_r  <= plot_nxt;
    end
  end

  assign x          = cx[7:0];
  assign y          = cy[6:0];
  assign colour_out = col_r;
  assign plot       = plot_r;
  // busy drops in the draw_done cycle so the controller can issue the next start right after it.
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign draw_done  = (state == S_DONE);

endmodule

// File: tb/tb_poly_drawer.sv
module tb_poly_drawer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  shape_base;
  logic [4:0]  num_vertices;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [2:0]  colour;
  logic [7:0]  vertex_addr;
  logic [15:0] vertex_data = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour_out;
  logic        plot;
  logic        busy;
  logic        draw_done;

  poly_drawer #(.ADDR_W(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .start(start), .shape_base(shape_base),
    .num_vertices(num_vertices), .origin_x(origin_x), .origin_y(origin_y),
    .colour(colour), .vertex_addr(vertex_addr), .vertex_data(vertex_data),
    .x(x), .y(y), .colour_out(colour_out), .plot(plot), .busy(busy),
    .draw_done(draw_done)
  );

  always #5 clk = ~clk;

  // Synchronous shape ROM: data follows the address by one clock.
  logic [15:0] rom [0:255];
  always @(posedge clk) vertex_data <= rom[vertex_addr];

  int vectors = 0;
  int fails   = 0;
  int px[$], py[$], pc[$];
  int done_cnt, done_cyc, va1, va3, busy_at_done, col_seen;
  int steep_x[8] = '{20, 20, 19, 19, 18, 18, 17, 17};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int i);
    if (i < px.size()) return px[i] * 256 + py[i];
    return -1;
  endfunction

  // Launches a draw (start high in cycle 0) and logs plots / done over cycles 1..budget.
  task automatic draw(input logic [7:0] b, input logic [4:0] n, input logic [7:0] ox,
                      input logic [6:0] oy, input logic [2:0] col, input int restart_at,
                      input int budget);
    px.delete(); py.delete(); pc.delete();
    done_cnt = 0; done_cyc = -1; va1 = -1; va3 = -1; busy_at_done = -1; col_seen = -1;
    shape_base = b; num_vertices = n; origin_x = ox; origin_y = oy; colour = col;
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      start        = (c == restart_at);
      shape_base   = b ^ 8'hA5;
      num_vertices = ~n;
      origin_x     = ox + 8'd77;
      origin_y     = oy ^ 7'h55;
      colour       = ~col;
      if (c == 1) va1 = vertex_addr;
      if (c == 3) va3 = vertex_addr;
      if (plot) begin
        px.push_back(x); py.push_back(y); pc.push_back(c);
        if (col_seen < 0) col_seen = colour_out;
      end
      if (draw_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int quiet_done, quiet_plot;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h10] = 16'h0000; rom[8'h11] = 16'h0400; rom[8'h12] = 16'h0004;
    rom[8'h20] = 16'h02FD;
    rom[8'h30] = 16'h0000; rom[8'h31] = 16'h0400;
    rom[8'h40] = 16'h0000; rom[8'h41] = 16'hFDF9;
    rom[8'h50] = 16'h0000; rom[8'h51] = 16'h0500; rom[8'h52] = 16'h0505; rom[8'h53] = 16'h0005;
    rom[8'hFF] = 16'h0101; rom[8'h00] = 16'h0301;

    reset = 1'b1; start = 1'b0; shape_base = '0; num_vertices = '0;
    origin_x = '0; origin_y = '0; colour = '0;
    #1;
    check("reset outputs", {plot, x, y, colour_out, busy, draw_done, vertex_addr}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Triangle (0,0),(4,0),(0,4) at (10,10)
    draw(8'h10, 5'd3, 8'd10, 7'd10, 3'd3, 0, 200);
    check("tri plots", px.size(), 15);
    check("tri first pixel", pix(0), 10 * 256 + 10);
    check("tri first cycle", (pc.size() > 0) ? pc[0] : -1, 6);
    check("tri diag 13,11", pix(6), 13 * 256 + 11);
    check("tri diag 12,12", pix(7), 12 * 256 + 12);
    check("tri diag 11,13", pix(8), 11 * 256 + 13);
    check("tri last pixel", pix(14), 10 * 256 + 10);
    check("tri done count", done_cnt, 1);
    check("tri done cycle", done_cyc, 28);
    check("tri colour", col_seen, 3);
    tick();

    // Single vertex (2,-3) at (50,50)
    draw(8'h20, 5'd1, 8'd50, 7'd50, 3'd5, 0, 200);
    check("n1 addr k+1", va1, 8'h20);
    check("n1 addr k+3", va3, 8'h21);
    check("n1 plots", px.size(), 1);
    check("n1 pixel", pix(0), 52 * 256 + 47);
    check("n1 pixel cycle", (pc.size() > 0) ? pc[0] : -1, 6);
    check("n1 done cycle", done_cyc, 8);
    check("n1 busy at done", busy_at_done, 0);
    tick();

    // Clipping at the right screen edge
    draw(8'h30, 5'd2, 8'd158, 7'd5, 3'd1, 0, 200);
    check("clip plots", px.size(), 4);
    check("clip px0", pix(0), 158 * 256 + 5);
    check("clip px1", pix(1), 159 * 256 + 5);
    check("clip px2", pix(2), 159 * 256 + 5);
    check("clip px3", pix(3), 158 * 256 + 5);
    check("clip done cycle", done_cyc, 19);
    check("clip done count", done_cnt, 1);
    tick();

    // Empty shape
    draw(8'h10, 5'd0, 8'd10, 7'd10, 3'd2, 0, 50);
    check("n0 done cycle", done_cyc, 1);
    check("n0 plots", px.size(), 0);
    check("n0 done count", done_cnt, 1);
    tick();

    // Second start mid-draw must be ignored
    draw(8'h10, 5'd3, 8'd10, 7'd10, 3'd3, 10, 200);
    check("guard done count", done_cnt, 1);
    check("guard done cycle", done_cyc, 28);
    check("guard plots", px.size(), 15);
    tick();

    // Steep negative slope (0,0)->(-3,-7) at (20,20)
    draw(8'h40, 5'd2, 8'd20, 7'd20, 3'd7, 0, 200);
    check("steep plots", px.size(), 16);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("steep x[%0d]", i), (i < px.size()) ? px[i] : -1, steep_x[i]);
      check($sformatf("steep y[%0d]", i), (i < py.size()) ? py[i] : -1, 20 - i);
    end
    tick();

    // ROM address wrap: vertices at 0xFF and 0x00
    draw(8'hFF, 5'd2, 8'd0, 7'd0, 3'd4, 0, 200);
    check("wrap addr k+1", va1, 8'hFF);
    check("wrap addr k+3", va3, 8'h00);
    check("wrap plots", px.size(), 6);
    check("wrap far end", pix(2), 3 * 256 + 1);
    tick();

    // Reset in the middle of a square's first edge
    shape_base = 8'h50; num_vertices = 5'd4; origin_x = 8'd30; origin_y = 7'd30; colour = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre-reset plot", plot, 1);
    reset = 1'b1;
    #1;
    check("mid reset plot", plot, 0);
    check("mid reset outputs", {plot, x, y, colour_out, busy, draw_done, vertex_addr}, 0);
    tick(); tick();
    reset = 1'b0;
    quiet_done = 0; quiet_plot = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (draw_done) quiet_done++;
      if (plot) quiet_plot++;
    end
    check("post reset done", quiet_done, 0);
    check("post reset plots", quiet_plot, 0);
    draw(8'h50, 5'd4, 8'd30, 7'd30, 3'd6, 0, 200);
    check("square plots", px.size(), 24);
    check("square done cycle", done_cyc, 41);
    check("square last pixel", pix(23), 30 * 256 + 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
